param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits, >= 1.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, a power of two, >= 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost_full asserts when count >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost_empty asserts when count <= AE_THRESH.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port write_en, input, 1 bit: write request.
REQ-008 SHALL have port data_in, input, DATA_W bits: write data.
REQ-009 SHALL have port read_en, input, 1 bit: read request.
REQ-010 SHALL have port data_out, output, DATA_W bits: read data.
REQ-011 SHALL have port valid_out, output, 1 bit: data_out holds valid read data.
REQ-012 SHALL have ports empty and full, each output, 1 bit: occupancy flags.
REQ-013 SHALL have ports almost_empty and almost_full, each output, 1 bit: threshold flags.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.

Function
REQ-016 SHALL accept a write iff write_en && !full; the write stores data_in at the write pointer and advances the pointer modulo DEPTH.
REQ-017 SHALL accept a read iff read_en && !empty; the read advances the read pointer modulo DEPTH.
REQ-018 SHALL evaluate full and empty from pre-edge state: when full, write_en && read_en accepts only the read (count becomes DEPTH-1); when empty, both accept only the write (count becomes 1).
REQ-019 SHALL apply count += (write accepted) - (read accepted) per cycle; a simultaneous accepted read and write leaves count unchanged.
REQ-020 SHALL drive empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_THRESH) and almost_empty = (count<=AE_THRESH), all combinational from the registered count.
REQ-021 SHALL set overflow on any cycle with write_en && full, and set underflow on any cycle with read_en && empty; both hold until reset.
REQ-022 SHALL leave memory, pointers and count unchanged by a rejected request.
REQ-023 SHALL wrap pointers by natural binary rollover; pointer width is $clog2(DEPTH).
REQ-024 SHALL hold data_out at its last value when no read is accepted (standard mode).

Reset
REQ-025 SHALL, on a clk edge with reset high, clear the pointers, count, overflow and underflow, set valid_out=0 and data_out=0, and drop any concurrent request regardless of current occupancy.
REQ-026 SHALL not clear memory contents on reset.
REQ-027 SHALL present empty=1, almost_empty=1, full=0 and almost_full=0 on the first cycle after reset.

Configuration
REQ-028 SHALL, when macro PARAM_SYNC_FIFO_FWFT_EN is defined, use first-word-fall-through: data_out = mem[read pointer] combinationally, valid_out = !empty, and an accepted read pops the entry shown that cycle (latency 0).
REQ-029 SHALL, when PARAM_SYNC_FIFO_FWFT_EN is undefined, register data_out on an accepted read and assert valid_out for exactly the following cycle (latency 1).

Structure
REQ-030 SHALL place the default DATA_W and DEPTH constants and a count-width helper function in package param_sync_fifo_pkg.
REQ-031 SHALL instantiate one sub-module, fifo_mem: DEPTH x DATA_W storage with one synchronous write port and one asynchronous read port.

Verification (DATA_W=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-032 SHALL cover: write 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full=1; 5th write 0x55 -> overflow=1, count stays 4.
REQ-033 SHALL cover: read four entries after REQ-032 -> data 0x11,0x22,0x33,0x44 in order (standard: valid_out one cycle after each read); extra read -> underflow=1, count=0.
REQ-034 SHALL cover: at count=2, simultaneous write and read for 10 cycles -> count stays 2, pointers wrap, output order preserved.
REQ-035 SHALL cover: at full, write_en && read_en -> read accepted, write rejected, overflow set, count=3; at empty, both -> count=1, underflow set.
REQ-036 SHALL cover: reset asserted at count=3 with write_en high -> next cycle count=0, empty=1, valid_out=0, overflow=0.
REQ-037 SHALL cover, with PARAM_SYNC_FIFO_FWFT_EN defined: write 0xA5 into empty FIFO -> next cycle data_out=0xA5 and valid_out=1 with no read issued.

Source files
------------

// File: rtl/param_sync_fifo_pkg.sv
// Shared defaults and the occupancy-counter width helper for param_sync_fifo.
package param_sync_fifo_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_DEPTH  = 16;

   // The counter needs one extra bit so it can represent a completely full FIFO (0..DEPTH).
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// DEPTH x DATA_W storage for param_sync_fifo: one synchronous write port, one asynchronous read port.
module fifo_mem
   import param_sync_fifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [DATA_W-1:0] read_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately left untouched by reset.
   always_ff @(posedge clk) begin
      if (write_en) begin
         mem[write_addr] <= write_data;
      end
   end

   assign read_data = mem[read_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with occupancy/threshold flags and sticky error flags.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise reads have one cycle of latency.
module param_sync_fifo
   import param_sync_fifo_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          write_en,
   input  logic [DATA_W-1:0]             data_in,
   input  logic                          read_en,
   output logic [DATA_W-1:0]             data_out,
   output logic                          valid_out,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_empty,
   output logic                          almost_full,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_width(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic              overflow_reg;
   logic              underflow_reg;
   logic              wr_accept;
   logic              rd_accept;
   logic [DATA_W-1:0] rd_data;

   assign empty        = (count_reg == '0);
   assign full         = (count_reg == CNT_W'(DEPTH));
   assign almost_full  = (count_reg >= CNT_W'(AF_THRESH));
   assign almost_empty = (count_reg <= CNT_W'(AE_THRESH));
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   // Reset wins over any concurrent request, so nothing is stored or popped on a reset edge.
   assign wr_accept = write_en && !full  && !reset;
   assign rd_accept = read_en  && !empty && !reset;

   always_comb begin
      count_next = count_reg;
      case ({wr_accept, rd_accept})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (wr_accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (rd_accept) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         if (write_en && full) begin
            overflow_reg <= 1'b1;
         end
         if (read_en && empty) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk        (clk),
      .write_en   (wr_accept),
      .write_addr (wr_ptr_reg),
      .write_data (data_in),
      .read_addr  (rd_ptr_reg),
      .read_data  (rd_data)
   );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
   // The head entry is always visible; a read pops exactly what is shown this cycle.
   assign data_out  = rd_data;
   assign valid_out = !empty;
`else
   logic [DATA_W-1:0] data_out_reg;
   logic              valid_out_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_reg  <= '0;
         valid_out_reg <= 1'b0;
      end else begin
         valid_out_reg <= rd_accept;
         if (rd_accept) begin
            data_out_reg <= rd_data;
         end
      end
   end

   assign data_out  = data_out_reg;
   assign valid_out = valid_out_reg;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed, table-driven bench for param_sync_fifo at DATA_W=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1.
module tb_param_sync_fifo;

   localparam int DW  = 8;
   localparam int DEP = 4;
   localparam int AF  = 3;
   localparam int AE  = 1;
   localparam int NV  = 22;

   logic          clk = 1'b0;
   logic          reset;
   logic          write_en;
   logic [DW-1:0] data_in;
   logic          read_en;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          empty;
   logic          full;
   logic          almost_empty;
   logic          almost_full;
   logic [2:0]    count;
   logic          overflow;
   logic          underflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   param_sync_fifo #(
      .DATA_W    (DW),
      .DEPTH     (DEP),
      .AF_THRESH (AF),
      .AE_THRESH (AE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .write_en     (write_en),
      .data_in      (data_in),
      .read_en      (read_en),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Inputs, then expected state after the edge: count, sticky flags,
   // registered-mode valid/data, and the head entry shown in fall-through mode.
   typedef struct {
      logic          we;
      logic [DW-1:0] din;
      logic          re;
      int            cnt;
      logic          ovf;
      logic          udf;
      logic          vld;
      logic [DW-1:0] data;
      logic [DW-1:0] head;
   } vec_t;

   vec_t vecs [NV];

   function automatic vec_t mk(input logic we, input logic [DW-1:0] din, input logic re,
                               input int cnt, input logic ovf, input logic udf,
                               input logic vld, input logic [DW-1:0] data, input logic [DW-1:0] head);
      vec_t v;
      v.we = we; v.din = din; v.re = re; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
      v.vld = vld; v.data = data; v.head = head;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic we, input logic [DW-1:0] din, input logic re);
      write_en = we;
      data_in  = din;
      read_en  = re;
      @(posedge clk);
      #1;
      write_en = 1'b0;
      read_en  = 1'b0;
      $display("txn rst=%0b we=%0b din=%02h re=%0b -> count=%0d empty=%0b full=%0b ae=%0b af=%0b ovf=%0b udf=%0b valid=%0b dout=%02h",
               reset, we, din, re, count, empty, full, almost_empty, almost_full,
               overflow, underflow, valid_out, data_out);
   endtask

   task automatic chk_flags(input string name, input int cnt);
      chk({name, ".count"}, int'(count), cnt);
      chk({name, ".empty"}, int'(empty), int'(cnt == 0));
      chk({name, ".full"}, int'(full), int'(cnt == DEP));
      chk({name, ".almost_full"}, int'(almost_full), int'(cnt >= AF));
      chk({name, ".almost_empty"}, int'(almost_empty), int'(cnt <= AE));
   endtask

   task automatic chk_sticky(input string name, input logic ovf, input logic udf);
      chk({name, ".overflow"}, int'(overflow), int'(ovf));
      chk({name, ".underflow"}, int'(underflow), int'(udf));
   endtask

   task automatic chk_out(input string name, input logic vld, input logic [DW-1:0] data,
                          input int cnt, input logic [DW-1:0] head);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      chk({name, ".valid_out"}, int'(valid_out), int'(cnt != 0));
      if (cnt != 0) begin
         chk({name, ".data_out"}, int'(data_out), int'(head));
      end
`else
      chk({name, ".valid_out"}, int'(valid_out), int'(vld));
      chk({name, ".data_out"}, int'(data_out), int'(data));
`endif
   endtask

   initial begin
      // Fill to full, overflow, drain, underflow, then ten wrapping read+write cycles at count 2.
      vecs[0]  = mk(1, 8'h11, 0, 1, 0, 0, 0, 8'h00, 8'h11);
      vecs[1]  = mk(1, 8'h22, 0, 2, 0, 0, 0, 8'h00, 8'h11);
      vecs[2]  = mk(1, 8'h33, 0, 3, 0, 0, 0, 8'h00, 8'h11);
      vecs[3]  = mk(1, 8'h44, 0, 4, 0, 0, 0, 8'h00, 8'h11);
      vecs[4]  = mk(1, 8'h55, 0, 4, 1, 0, 0, 8'h00, 8'h11);
      vecs[5]  = mk(0, 8'h00, 1, 3, 1, 0, 1, 8'h11, 8'h22);
      vecs[6]  = mk(0, 8'h00, 1, 2, 1, 0, 1, 8'h22, 8'h33);
      vecs[7]  = mk(0, 8'h00, 1, 1, 1, 0, 1, 8'h33, 8'h44);
      vecs[8]  = mk(0, 8'h00, 1, 0, 1, 0, 1, 8'h44, 8'h00);
      vecs[9]  = mk(0, 8'h00, 1, 0, 1, 1, 0, 8'h44, 8'h00);
      vecs[10] = mk(1, 8'h01, 0, 1, 1, 1, 0, 8'h44, 8'h01);
      vecs[11] = mk(1, 8'h02, 0, 2, 1, 1, 0, 8'h44, 8'h01);
      for (int i = 0; i < 10; i++) begin
         vecs[12 + i] = mk(1, 8'(3 + i), 1, 2, 1, 1, 1, 8'(1 + i), 8'(2 + i));
      end

      reset    = 1'b1;
      write_en = 1'b0;
      read_en  = 1'b0;
      data_in  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_flags("reset", 0);
      chk_sticky("reset", 0, 0);
      chk_out("reset", 0, 8'h00, 0, 8'h00);

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].we, vecs[i].din, vecs[i].re);
         chk_flags($sformatf("vec%0d", i), vecs[i].cnt);
         chk_sticky($sformatf("vec%0d", i), vecs[i].ovf, vecs[i].udf);
         chk_out($sformatf("vec%0d", i), vecs[i].vld, vecs[i].data, vecs[i].cnt, vecs[i].head);
      end

      // Reset at count 3 with a concurrent write: the write is dropped.
      step(1, 8'h0D, 0);
      chk_flags("pre_rst", 3);
      reset = 1'b1;
      step(1, 8'hEE, 0);
      reset = 1'b0;
      chk_flags("rst_mid", 0);
      chk_sticky("rst_mid", 0, 0);
      chk_out("rst_mid", 0, 8'h00, 0, 8'h00);

      // Read+write while full: only the read is taken.
      step(1, 8'hA1, 0);
      step(1, 8'hA2, 0);
      step(1, 8'hA3, 0);
      step(1, 8'hA4, 0);
      chk_flags("fill", 4);
      step(1, 8'hA5, 1);
      chk_flags("rw_full", 3);
      chk_sticky("rw_full", 1, 0);
      chk_out("rw_full", 1, 8'hA1, 3, 8'hA2);
      step(0, 8'h00, 1);
      chk_out("drain1", 1, 8'hA2, 2, 8'hA3);
      step(0, 8'h00, 1);
      chk_out("drain2", 1, 8'hA3, 1, 8'hA4);
      step(0, 8'h00, 1);
      chk_out("drain3", 1, 8'hA4, 0, 8'h00);
      chk_flags("drain3", 0);

      // Read+write while empty: only the write is taken.
      step(1, 8'hB6, 1);
      chk_flags("rw_empty", 1);
      chk_sticky("rw_empty", 1, 1);
      chk_out("rw_empty", 0, 8'hA4, 1, 8'hB6);

      // Single write into an empty FIFO with no read.
      reset = 1'b1;
      step(0, 8'h00, 0);
      reset = 1'b0;
      step(1, 8'hA5, 0);
      chk_flags("lone_wr", 1);
      chk_out("lone_wr", 0, 8'h00, 1, 8'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
